// File: rtl/gcd_rr_scheduler_pkg.sv
// Shared definitions for the round-robin GCD scheduler: one-hot state codes,
// engine width and a constant-evaluable clog2.
package gcd_sched_pkg;

   localparam int GCD_W = 8;

   localparam logic [4:0] ST_IDLE  = 5'b00001;
   localparam logic [4:0] ST_LOAD  = 5'b00010;
   localparam logic [4:0] ST_RUN   = 5'b00100;
   localparam logic [4:0] ST_ACK   = 5'b01000;
   localparam logic [4:0] ST_DRAIN = 5'b10000;

   typedef enum logic [4:0] {
      S_IDLE  = ST_IDLE,
      S_LOAD  = ST_LOAD,
      S_RUN   = ST_RUN,
      S_ACK   = ST_ACK,
      S_DRAIN = ST_DRAIN
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/gcd_rr_scheduler_if.sv
// Requester-side and engine-side signals of the scheduler. Handshake: a
// requester holds Req and its operands until Gnt; the scheduler holds
// Eng_Start until the engine leaves q_I and pulses Eng_Ack once per q_Done.
interface gcd_rr_scheduler_if
   import gcd_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = GCD_W
);
   localparam int IW = clog2(N);

   logic [N-1:0]   Req;
   logic [N*W-1:0] Ain_bus;
   logic [N*W-1:0] Bin_bus;
   logic [N-1:0]   Gnt;
   logic [N-1:0]   Done;
   logic [W-1:0]   Result;
   logic           Busy;
   logic [IW-1:0]  Owner;
   logic           Eng_Start;
   logic           Eng_Ack;
   logic [W-1:0]   Eng_Ain;
   logic [W-1:0]   Eng_Bin;
   logic           Eng_qI;
   logic           Eng_qDone;
   logic [W-1:0]   Eng_GCD;
   logic [4:0]     State;

   modport slave (
      input  Req, Ain_bus, Bin_bus, Eng_qI, Eng_qDone, Eng_GCD,
      output Gnt, Done, Result, Busy, Owner, Eng_Start, Eng_Ack,
             Eng_Ain, Eng_Bin, State
   );

   modport master (
      output Req, Ain_bus, Bin_bus, Eng_qI, Eng_qDone, Eng_GCD,
      input  Gnt, Done, Result, Busy, Owner, Eng_Start, Eng_Ack,
             Eng_Ain, Eng_Bin, State
   );

endinterface

// File: rtl/gcd_rr_scheduler_pick.sv
// Combinational round-robin picker: first set Req bit searching upward from
// Last+1 with wrap-around, so Last itself has the lowest priority.
module gcd_rr_pick
   import gcd_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  Req,
   input  logic [IW-1:0] Last,
   output logic          Any,
   output logic [IW-1:0] Idx
);

   always_comb begin
      int j;
      j   = 0;
      Any = 1'b0;
      Idx = '0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(Last) + k) % N;
         if (!Any && Req[j]) begin
            Any = 1'b1;
            Idx = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin scheduler sharing one ee354_GCD engine among N requesters.
// Optional GCD_ZERO_GUARD_EN: zero operands bypass the engine (Result = A|B).
module gcd_rr_scheduler
   import gcd_sched_pkg::*;
#(
   parameter int N = 4,
   parameter int W = GCD_W
) (
   input  logic                Clk,
   input  logic                Reset_n,
   gcd_rr_scheduler_if.slave   bus
);

   localparam int IW = clog2(N);

   state_t         state_q;
   logic [IW-1:0]  owner_q;
   logic [IW-1:0]  last_q;
   logic [N-1:0]   gnt_q;
   logic [W-1:0]   result_q;
   logic [W-1:0]   ain_q;
   logic [W-1:0]   bin_q;
   logic           bypass_q;

   logic           pick_any;
   logic [IW-1:0]  pick_idx;
   logic [W-1:0]   ain_d;
   logic [W-1:0]   bin_d;

   gcd_rr_pick #(.N(N), .IW(IW)) u_pick (
      .Req  (bus.Req),
      .Last (last_q),
      .Any  (pick_any),
      .Idx  (pick_idx)
   );

   assign ain_d = bus.Ain_bus[W*int'(pick_idx) +: W];
   assign bin_d = bus.Bin_bus[W*int'(pick_idx) +: W];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         last_q   <= IW'(N-1);
         gnt_q    <= '0;
         result_q <= '0;
         ain_q    <= '0;
         bin_q    <= '0;
         bypass_q <= 1'b0;
      end else begin
         gnt_q <= '0;
         case (state_q)
            S_IDLE: begin
               bypass_q <= 1'b0;
               if (pick_any) begin
                  ain_q   <= ain_d;
                  bin_q   <= bin_d;
                  owner_q <= pick_idx;
                  last_q  <= pick_idx;
                  gnt_q   <= N'(1) << pick_idx;
`ifdef GCD_ZERO_GUARD_EN
                  // Zero operands would stall the subtractive engine forever.
                  if (ain_d == '0 || bin_d == '0) begin
                     result_q <= ain_d | bin_d;
                     bypass_q <= 1'b1;
                     state_q  <= S_ACK;
                  end else begin
                     state_q  <= S_LOAD;
                  end
`else
                  state_q <= S_LOAD;
`endif
               end
            end
            S_LOAD: begin
               if (!bus.Eng_qI) state_q <= S_RUN;
            end
            S_RUN: begin
               if (bus.Eng_qDone) begin
                  result_q <= bus.Eng_GCD;
                  state_q  <= S_ACK;
               end
            end
            S_ACK: begin
               state_q <= bypass_q ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
               if (bus.Eng_qI) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.Gnt       = gnt_q;
   assign bus.Done      = (state_q == S_ACK) ? (N'(1) << owner_q) : '0;
   assign bus.Result    = result_q;
   assign bus.Busy      = (state_q != S_IDLE);
   assign bus.Owner     = owner_q;
   assign bus.Eng_Start = (state_q == S_LOAD);
   assign bus.Eng_Ack   = (state_q == S_ACK) && !bypass_q;
   assign bus.Eng_Ain   = ain_q;
   assign bus.Eng_Bin   = bin_q;
   assign bus.State     = state_q;

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Bench for gcd_rr_scheduler with a behavioural subtractive GCD engine and a
// round-robin / Euclid reference model. Honours GCD_ZERO_GUARD_EN.
module tb_gcd_rr_scheduler;

   localparam int N = 4;
   localparam int W = 8;
   localparam logic [4:0] ST_IDLE_C = 5'b00001;
   localparam logic [4:0] ST_RUN_C  = 5'b00100;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   gcd_rr_scheduler_if #(.N(N), .W(W)) bus ();

   gcd_rr_scheduler #(.N(N), .W(W)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural engine: I -> SUB -> DONE (-> LAG when eng_lag) -> I
   int           e_st;
   logic [W-1:0] ea, eb;
   bit           eng_lag;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_st <= 0;
         ea   <= '0;
         eb   <= '0;
      end else begin
         case (e_st)
            0: if (bus.Eng_Start) begin ea <= bus.Eng_Ain; eb <= bus.Eng_Bin; e_st <= 1; end
            1: if (ea == eb) e_st <= 2;
               else if (ea > eb) ea <= ea - eb;
               else eb <= eb - ea;
            2: if (bus.Eng_Ack) e_st <= eng_lag ? 3 : 0;
            default: e_st <= 0;
         endcase
      end
   end

   assign bus.Eng_qI    = (e_st == 0);
   assign bus.Eng_qDone = (e_st == 2) || (e_st == 3);
   assign bus.Eng_GCD   = ea;

   // monitor counters
   int start_cnt, ack_cnt, done_cnt, gnt_cnt, overlap_cnt;
   always @(negedge clk) begin
      if (bus.Eng_Start) start_cnt++;
      if (bus.Eng_Ack)   ack_cnt++;
      if (bus.Done != '0) done_cnt++;
      if (bus.Gnt != '0)  gnt_cnt++;
      if (bus.Eng_Start && bus.Eng_Ack) overlap_cnt++;
   end

   // reference model
   int m_last;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] op_a[N];
   logic [W-1:0] op_b[N];

   function automatic int model_pick(input logic [N-1:0] req, input int last);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int x, y, t;
      x = a; y = b;
      while (y != 0) begin t = x % y; x = y; y = t; end
      return W'(x);
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // driver tasks
   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i] = a;
      op_b[i] = b;
      bus.Ain_bus[W*i +: W] = a;
      bus.Bin_bus[W*i +: W] = b;
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      bus.Req = '0;
      eng_lag = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_last = N - 1;
      exp_q.delete();
   endtask

   task automatic wait_gnt(input int bound, output int cyc, output logic [N-1:0] g);
      cyc = -1;
      g = '0;
      for (int c = 1; c <= bound; c++) begin
         @(negedge clk);
         if (bus.Gnt != '0) begin cyc = c; g = bus.Gnt; break; end
      end
   endtask

   task automatic wait_done(input int bound, output int cyc, output logic [N-1:0] d,
                            output logic [W-1:0] r);
      cyc = -1;
      d = '0;
      r = '0;
      for (int c = 1; c <= bound; c++) begin
         @(negedge clk);
         if (bus.Done != '0) begin cyc = c; d = bus.Done; r = bus.Result; break; end
      end
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < bound; c++) begin
         if (!bus.Busy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   // one full operation for requester i; exp idx from the model
   task automatic run_one(input string tag, input logic [N-1:0] mask);
      int cyc, ei;
      logic [N-1:0] g, d;
      logic [W-1:0] r, e;
      bit ok;
      @(negedge clk);
      bus.Req = mask;
      ei = model_pick(mask, m_last);
      wait_gnt(20, cyc, g);
      checks++;
      if (g !== onehot(ei)) begin
         errors++;
         $display("FAIL %s gnt: got %b want %b", tag, g, onehot(ei));
      end
      m_last = ei;
      exp_q.push_back(gcd_ref(op_a[ei], op_b[ei]));
      bus.Req = '0;
      wait_done(700, cyc, d, r);
      e = exp_q.pop_front();
      checks++;
      if (d !== onehot(ei) || r !== e) begin
         errors++;
         $display("FAIL %s done: got done=%b result=%0d want done=%b result=%0d",
                  tag, d, r, onehot(ei), e);
      end
      wait_idle(20, ok);
   endtask

   task automatic test_reset();
      reset_dut();
      @(negedge clk);
      checks++;
      if (bus.Gnt !== '0 || bus.Done !== '0 || bus.Result !== '0 || bus.Busy !== 1'b0 ||
          bus.Owner !== '0 || bus.Eng_Start !== 1'b0 || bus.Eng_Ack !== 1'b0 ||
          bus.Eng_Ain !== '0 || bus.Eng_Bin !== '0 || bus.State !== ST_IDLE_C) begin
         errors++;
         $display("FAIL reset_state: gnt=%b done=%b res=%0d busy=%b own=%0d st=%b want all 0, st=00001",
                  bus.Gnt, bus.Done, bus.Result, bus.Busy, bus.Owner, bus.State);
      end
   endtask

   task automatic test_single();
      int cyc, s0;
      logic [N-1:0] g, d;
      logic [W-1:0] r;
      bit ok;
      set_ops(0, 8'd36, 8'd24);
      s0 = start_cnt;
      @(negedge clk);
      bus.Req = 4'b0001;
      wait_gnt(20, cyc, g);
      checks++;
      if (g !== 4'b0001 || cyc != 1) begin
         errors++;
         $display("FAIL single_gnt: got %b after %0d cycles want 0001 after 1", g, cyc);
      end
      checks++;
      if (bus.Eng_Ain !== 8'd36 || bus.Eng_Bin !== 8'd24 || bus.Eng_Start !== 1'b1) begin
         errors++;
         $display("FAIL single_load: ain=%0d bin=%0d start=%b want 36 24 1",
                  bus.Eng_Ain, bus.Eng_Bin, bus.Eng_Start);
      end
      bus.Req = '0;
      m_last = 0;
      wait_done(200, cyc, d, r);
      checks++;
      if (d !== 4'b0001 || r !== 8'd12 || bus.Eng_Start !== 1'b0 || bus.Eng_Ain !== 8'd36) begin
         errors++;
         $display("FAIL single_done: done=%b res=%0d start=%b ain=%0d want 0001 12 0 36",
                  d, r, bus.Eng_Start, bus.Eng_Ain);
      end
      wait_idle(20, ok);
      checks++;
      if (!ok || start_cnt == s0) begin
         errors++;
         $display("FAIL single_idle: idle=%0d start_cycles=%0d want idle=1 start_cycles>0",
                  ok, start_cnt - s0);
      end
   endtask

   task automatic test_round_robin();
      int cyc, ei;
      logic [N-1:0] g, d;
      logic [W-1:0] r, e;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      reset_dut();
      set_ops(0, 8'd12, 8'd8);
      set_ops(1, 8'd7,  8'd5);
      set_ops(2, 8'd40, 8'd16);
      set_ops(3, 8'd9,  8'd9);
      bus.Req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(40, cyc, g);
         ei = model_pick(4'b1111, m_last);
         checks++;
         if (g !== onehot(ei) || ei != exp_order[k]) begin
            errors++;
            $display("FAIL rr_gnt%0d: got %b want %b", k, g, onehot(exp_order[k]));
         end
         m_last = ei;
         exp_q.push_back(gcd_ref(op_a[ei], op_b[ei]));
         wait_done(200, cyc, d, r);
         e = exp_q.pop_front();
         checks++;
         if (d !== onehot(ei) || r !== e) begin
            errors++;
            $display("FAIL rr_done%0d: done=%b res=%0d want %b %0d", k, d, r, onehot(ei), e);
         end
         if (k == 4) bus.Req = '0;
      end
   endtask

   task automatic test_drop_req();
      int cyc, g0;
      logic [N-1:0] g, d;
      logic [W-1:0] r;
      bit ok;
      set_ops(2, 8'd48, 8'd18);
      @(negedge clk);
      bus.Req = 4'b0100;
      wait_gnt(20, cyc, g);
      m_last = 2;
      repeat (2) @(negedge clk);
      bus.Req = '0;
      g0 = gnt_cnt;
      wait_done(200, cyc, d, r);
      checks++;
      if (d !== 4'b0100 || r !== 8'd6) begin
         errors++;
         $display("FAIL drop_done: done=%b res=%0d want 0100 6", d, r);
      end
      wait_idle(20, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (gnt_cnt != g0) begin
         errors++;
         $display("FAIL drop_nogrant: extra grants %0d want 0", gnt_cnt - g0);
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      bit seen;
      logic [N-1:0] g;
      set_ops(1, 8'd200, 8'd1);
      @(negedge clk);
      bus.Req = 4'b0010;
      wait_gnt(20, cyc, g);
      bus.Req = '0;
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.State === ST_RUN_C) begin seen = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!seen || bus.Gnt !== '0 || bus.Done !== '0 || bus.Result !== '0 || bus.Busy !== 1'b0 ||
          bus.Owner !== '0 || bus.Eng_Start !== 1'b0 || bus.Eng_Ack !== 1'b0 ||
          bus.Eng_Ain !== '0 || bus.Eng_Bin !== '0 || bus.State !== ST_IDLE_C) begin
         errors++;
         $display("FAIL async_reset: run_seen=%0d busy=%b res=%0d own=%0d ain=%0d st=%b want 1 0 0 0 0 00001",
                  seen, bus.Busy, bus.Result, bus.Owner, bus.Eng_Ain, bus.State);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_last = N - 1;
      set_ops(1, 8'd21, 8'd14);
      run_one("post_reset", 4'b0010);
   endtask

   task automatic test_lagging_engine();
      int d0, a0;
      reset_dut();
      eng_lag = 1'b1;
      set_ops(3, 8'd30, 8'd12);
      d0 = done_cnt;
      a0 = ack_cnt;
      run_one("lag", 4'b1000);
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt - d0 != 1 || ack_cnt - a0 != 1) begin
         errors++;
         $display("FAIL lag_pulses: done_cycles=%0d ack_cycles=%0d want 1 1",
                  done_cnt - d0, ack_cnt - a0);
      end
      eng_lag = 1'b0;
   endtask

   task automatic test_random();
      logic [N-1:0] mask;
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < N; i++)
            set_ops(i, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
         mask = N'($urandom_range(1, (1 << N) - 1));
         run_one($sformatf("rand%0d", k), mask);
      end
   endtask

   task automatic test_zero_guard();
      int cyc, gc, s0;
      logic [N-1:0] g, d;
      logic [W-1:0] r;
      reset_dut();
      set_ops(0, 8'd0, 8'd15);
      s0 = start_cnt;
      @(negedge clk);
      bus.Req = 4'b0001;
      wait_gnt(20, cyc, g);
      bus.Req = '0;
      gc = cyc;
`ifdef GCD_ZERO_GUARD_EN
      if (bus.Done != '0) begin cyc = 0; d = bus.Done; r = bus.Result; end
      else wait_done(2, cyc, d, r);
      repeat (4) @(negedge clk);
      checks++;
      if (gc < 0 || cyc < 0 || d !== 4'b0001 || r !== 8'd15 || start_cnt != s0) begin
         errors++;
         $display("FAIL zero_guard: done=%b res=%0d delay=%0d start_cycles=%0d want 0001 15 <=2 0",
                  d, r, cyc, start_cnt - s0);
      end
`else
      repeat (3) @(negedge clk);
      d = '0;
      r = '0;
      checks++;
      if (gc < 0 || start_cnt == s0) begin
         errors++;
         $display("FAIL zero_forward: gnt_delay=%0d start_cycles=%0d want start_cycles>0",
                  gc, start_cnt - s0);
      end
`endif
      reset_dut();
   endtask

   task automatic test_no_overlap();
      checks++;
      if (overlap_cnt != 0) begin
         errors++;
         $display("FAIL start_ack_overlap: %0d cycles want 0", overlap_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      start_cnt = 0; ack_cnt = 0; done_cnt = 0; gnt_cnt = 0; overlap_cnt = 0;
      rst_n = 1'b1;
      eng_lag = 1'b0;
      bus.Req = '0;
      bus.Ain_bus = '0;
      bus.Bin_bus = '0;
      for (int i = 0; i < N; i++) begin op_a[i] = '0; op_b[i] = '0; end
      m_last = N - 1;
      test_reset();
      test_single();
      test_round_robin();
      test_drop_req();
      test_reset_mid_run();
      test_lagging_engine();
      test_random();
      test_zero_guard();
      test_no_overlap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcd_rr_scheduler.md
Name: gcd_rr_scheduler

Overview:
Shares one ee354_GCD engine among N requesters using round-robin arbitration. It latches the granted requester's operands and drives the engine's Start/Ack handshake. It monitors the engine's one-hot state outputs and returns the result to the owning requester with a one-cycle Done pulse. It sits between the requester ports and the single GCD engine instance.

Parameters:
N, 4, number of requesters (2..8)
W, 8, operand/result width; must equal the engine width (8)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Req  in  N  per-requester request level; operands must be stable while high
Ain_bus  in  N*W  requester i's A operand at [W*i +: W]
Bin_bus  in  N*W  requester i's B operand at [W*i +: W]
Gnt  out  N  one-hot, one-cycle pulse: request accepted, operands captured
Done  out  N  one-hot, one-cycle pulse: result valid on Result
Result  out  W  GCD of the completed request; held until the next completion
Busy  out  1  high whenever the state is not IDLE
Owner  out  clog2(N)  index of the current/last granted requester
Eng_Start  out  1  to engine Start
Eng_Ack  out  1  to engine Ack
Eng_Ain  out  W  to engine Ain; registered
Eng_Bin  out  W  to engine Bin; registered
Eng_qI  in  1  engine q_I
Eng_qDone  in  1  engine q_Done
Eng_GCD  in  W  engine AB_GCD

Behaviour:
- Reset (Reset_n low, asynchronous) clears all outputs and registers to 0, sets state = IDLE, and sets the round-robin pointer Last to N-1, so requester 0 has top priority first.
- The state register is one-hot: IDLE, LOAD, RUN, ACK, DRAIN.
- IDLE
  - If any Req bit is high, pick the first set bit searching from Last+1 upward, with wrap-around.
  - Register that requester's operands into Eng_Ain/Eng_Bin, set Owner and Last to it, and pulse Gnt[Owner].
  - Go to LOAD.
  - If no Req bit is high, stay in IDLE.
- LOAD: Eng_Start = 1. When Eng_qI == 0 (engine has left its I state), go to RUN.
- RUN: Eng_Start = 0. When Eng_qDone == 1, set Result <= Eng_GCD and go to ACK.
- ACK: Eng_Ack = 1 and Done[Owner] = 1 for exactly this cycle. Go to DRAIN.
- DRAIN: Eng_Ack = 0. When Eng_qI == 1, go to IDLE.
- Eng_Start and Eng_Ack are decoded from the state register. They are never high together.
- Latency:
  - Gnt occurs in the cycle after Req is seen in IDLE.
  - Done occurs 1 cycle after Eng_qDone is first seen.
  - The earliest back-to-back grant is the cycle after DRAIN exits.
- Eng_Ain/Eng_Bin change only on a grant. They stay stable for the entire operation.
- If Req[Owner] drops mid-operation, the operation still completes and Done is still pulsed.
- A requester that keeps Req high after Done is treated as a new request. It has the lowest priority because Last = Owner.
- Simultaneous requests: exactly one grant per arbitration. No requester waits more than N-1 other operations.
- Gnt, Done and Eng_* are don't-care only for N index bits outside the range; all real bits are driven.
- If Reset_n is asserted mid-operation, the block returns to IDLE immediately. The system must reset the engine at the same time; the engine reset is not generated here.
- An illegal state (not one-hot) recovers to IDLE on the next clock.

Optional Feature:
GCD_ZERO_GUARD_EN
- Defined:
  - In IDLE, if the granted operands have A == 0 or B == 0, the engine is bypassed.
  - Result <= A | B, so gcd(0,0) = 0 and gcd(x,0) = x.
  - The state goes directly to ACK, with Eng_Ack suppressed and Done pulsed.
  - The state then goes to IDLE, skipping DRAIN.
  - This prevents engine lock-up on zero operands.
- Undefined:
  - Zero operands are forwarded to the engine unchanged.
  - Behaviour is the engine's; the engine can hang.

Decomposition:
- Package gcd_sched_pkg:
  - one-hot state localparams (IDLE=5'b00001, LOAD=5'b00010, RUN=5'b00100, ACK=5'b01000, DRAIN=5'b10000)
  - GCD_W = 8
  - clog2 function
- Sub-module gcd_rr_pick: combinational round-robin picker.
  - Inputs: Req[N], Last.
  - Outputs: Any, Idx.
  - The picker is instantiated once.

Test Plan:
1. Req=4'b0001 with A0=36, B0=24, driving a real engine → Gnt[0] pulse, Eng_Start high until Eng_qI falls, Done[0] pulse with Result=12, Busy low after DRAIN.
2. Req=4'b1111 held high; operands (A,B) = (12,8), (7,5), (40,16), (9,9) → grants in order 0,1,2,3,0 with Results 4, 1, 8, 9.
3. Req[2] raised, then dropped 2 cycles after Gnt[2], with (A,B) = (48,18) → operation completes, Done[2] pulses, Result=6, no new grant.
4. Reset_n pulsed low while in RUN → all outputs 0 asynchronously, state IDLE; the next Req[1] is granted normally.
5. Behavioural engine model holding Eng_qDone for 3 cycles → exactly one Done and one Eng_Ack cycle; the checker confirms Eng_Start and Eng_Ack are never high together.
6. With GCD_ZERO_GUARD_EN, (A,B) = (0,15) → Done with Result=15 within 2 cycles of Gnt, Eng_Start never high. Without the macro, Eng_Start is asserted.
